// File: rtl/bs_dev_port_if.sv
// Bus-slot handshake between bs_gnrtr_n_rbtr and one device port.
// master = bus generator/arbiter side, slave = device port side.
interface bs_dev_port_if #(
  parameter int pckg_sz = 16
);
  logic               pndng;
  logic [pckg_sz-1:0] D_pop;
  logic               pop;
  logic               push;
  logic [pckg_sz-1:0] D_push;

  modport master (
    input  pndng,
    input  D_pop,
    output pop,
    output push,
    output D_push
  );

  modport slave (
    output pndng,
    output D_pop,
    input  pop,
    input  push,
    input  D_push
  );
endinterface

// File: rtl/bs_dev_port.sv
// Device-side bus endpoint: outbound TX FIFO drained by the bus, inbound RX FIFO
// filled by the bus with destination-ID filtering and saturating drop counters.
module bs_dev_port #(
  parameter int         pckg_sz   = 16,
  parameter int         deep_fifo = 8,
  parameter logic [7:0] dev_id    = 8'h00,
  parameter logic [7:0] bcast_id  = 8'hFF,
  parameter int         cnt_w     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  bs_dev_port_if.slave               bus,
  input  logic                       tx_wr,
  input  logic [pckg_sz-1:0]         tx_data,
  output logic                       tx_full,
  output logic [$clog2(deep_fifo):0] tx_cnt,
  input  logic                       rx_rd,
  output logic [pckg_sz-1:0]         rx_data,
  output logic                       rx_valid,
  output logic [$clog2(deep_fifo):0] rx_cnt,
  output logic [cnt_w-1:0]           ovf_cnt,
  output logic [cnt_w-1:0]           mis_cnt,
  output logic                       err_pop
);

  localparam int AW = $clog2(deep_fifo);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(deep_fifo);

  logic [pckg_sz-1:0] tx_mem [deep_fifo];
  logic [pckg_sz-1:0] rx_mem [deep_fifo];

  logic [AW-1:0]    tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [CW-1:0]    tx_cnt_q, tx_cnt_d;
  logic [AW-1:0]    rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [CW-1:0]    rx_cnt_q, rx_cnt_d;
  logic [cnt_w-1:0] ovf_cnt_q, ovf_cnt_d, mis_cnt_q, mis_cnt_d;
  logic             err_pop_q, err_pop_d;

  logic       tx_pop_ok, tx_wr_ok, rx_rd_ok, rx_wr_ok, rx_full;
  logic       dest_match;
  logic [7:0] dest;

  assign dest       = bus.D_push[pckg_sz-1 -: 8];
  assign dest_match = (dest == dev_id) || (dest == bcast_id);

  // A pop on a full FIFO frees the slot the simultaneous write lands in.
  assign tx_pop_ok = bus.pop && (tx_cnt_q != '0);
  assign tx_wr_ok  = tx_wr && ((tx_cnt_q != DEPTH) || tx_pop_ok);
  assign rx_full   = (rx_cnt_q == DEPTH);
  assign rx_rd_ok  = rx_rd && (rx_cnt_q != '0);
  assign rx_wr_ok  = bus.push && dest_match && (!rx_full || rx_rd_ok);

  always_comb begin
    tx_wp_d   = tx_wp_q;
    tx_rp_d   = tx_rp_q;
    tx_cnt_d  = tx_cnt_q;
    rx_wp_d   = rx_wp_q;
    rx_rp_d   = rx_rp_q;
    rx_cnt_d  = rx_cnt_q;
    ovf_cnt_d = ovf_cnt_q;
    mis_cnt_d = mis_cnt_q;
    err_pop_d = err_pop_q;

    if (tx_wr_ok)  tx_wp_d = tx_wp_q + 1'b1;
    if (tx_pop_ok) tx_rp_d = tx_rp_q + 1'b1;
    if (tx_wr_ok && !tx_pop_ok)      tx_cnt_d = tx_cnt_q + 1'b1;
    else if (!tx_wr_ok && tx_pop_ok) tx_cnt_d = tx_cnt_q - 1'b1;
    if (bus.pop && (tx_cnt_q == '0)) err_pop_d = 1'b1;

    if (rx_wr_ok) rx_wp_d = rx_wp_q + 1'b1;
    if (rx_rd_ok) rx_rp_d = rx_rp_q + 1'b1;
    if (rx_wr_ok && !rx_rd_ok)      rx_cnt_d = rx_cnt_q + 1'b1;
    else if (!rx_wr_ok && rx_rd_ok) rx_cnt_d = rx_cnt_q - 1'b1;

    if (bus.push && dest_match && rx_full && !rx_rd_ok && (ovf_cnt_q != '1))
      ovf_cnt_d = ovf_cnt_q + 1'b1;
    if (bus.push && !dest_match && (mis_cnt_q != '1))
      mis_cnt_d = mis_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wp_q   <= '0;
      tx_rp_q   <= '0;
      tx_cnt_q  <= '0;
      rx_wp_q   <= '0;
      rx_rp_q   <= '0;
      rx_cnt_q  <= '0;
      ovf_cnt_q <= '0;
      mis_cnt_q <= '0;
      err_pop_q <= 1'b0;
    end else begin
      tx_wp_q   <= tx_wp_d;
      tx_rp_q   <= tx_rp_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_wp_q   <= rx_wp_d;
      rx_rp_q   <= rx_rp_d;
      rx_cnt_q  <= rx_cnt_d;
      ovf_cnt_q <= ovf_cnt_d;
      mis_cnt_q <= mis_cnt_d;
      err_pop_q <= err_pop_d;
    end
  end

  // Storage is deliberately left out of reset; the occupancy counters gate visibility.
  always_ff @(posedge clk) begin
    if (tx_wr_ok) tx_mem[tx_wp_q] <= tx_data;
    if (rx_wr_ok) rx_mem[rx_wp_q] <= bus.D_push;
  end

  assign bus.pndng = (tx_cnt_q != '0);
  assign bus.D_pop = bus.pndng ? tx_mem[tx_rp_q] : '0;
  assign tx_full   = (tx_cnt_q == DEPTH);
  assign tx_cnt    = tx_cnt_q;
  assign rx_valid  = (rx_cnt_q != '0);
  assign rx_data   = rx_valid ? rx_mem[rx_rp_q] : '0;
  assign rx_cnt    = rx_cnt_q;
  assign ovf_cnt   = ovf_cnt_q;
  assign mis_cnt   = mis_cnt_q;
  assign err_pop   = err_pop_q;

endmodule
